// File: rtl/uart_fifo_bridge_if.sv
`default_nettype none
// ============================================================================
// uart_fifo_bridge_if : host-side and UART-side signal bundle for the bridge
// Revision: 1.0
// ============================================================================
interface uart_fifo_bridge_if #(
  parameter int DEPTH_BITS = 4
);
  logic                  uart_received;
  logic [7:0]            uart_rx_byte;
  logic                  uart_rx_error;
  logic                  uart_is_transmitting;
  logic                  uart_transmit;
  logic [7:0]            uart_tx_byte;
  logic                  wr_stb;
  logic [7:0]            wr_data;
  logic                  tx_full;
  logic [DEPTH_BITS:0]   tx_count;
  logic                  rd_stb;
  logic [7:0]            rd_data;
  logic                  rx_empty;
  logic [DEPTH_BITS:0]   rx_count;
  logic                  rx_overflow;
  logic [7:0]            rx_err_count;
  logic                  status_clear;

  modport slave (
    input  uart_received, uart_rx_byte, uart_rx_error, uart_is_transmitting,
    input  wr_stb, wr_data, rd_stb, status_clear,
    output uart_transmit, uart_tx_byte, tx_full, tx_count,
    output rd_data, rx_empty, rx_count, rx_overflow, rx_err_count
  );

  modport master (
    output uart_received, uart_rx_byte, uart_rx_error, uart_is_transmitting,
    output wr_stb, wr_data, rd_stb, status_clear,
    input  uart_transmit, uart_tx_byte, tx_full, tx_count,
    input  rd_data, rx_empty, rx_count, rx_overflow, rx_err_count
  );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// uart_fifo_bridge : TX/RX byte FIFOs between a host and a UART, with launcher
// Revision: 1.0
// ============================================================================
module uart_fifo_bridge #(
  parameter int DEPTH_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  uart_fifo_bridge_if.slave  bus
);
  localparam int             DEPTH    = 1 << DEPTH_BITS;
  localparam int             CW       = DEPTH_BITS + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_WAIT_BUSY = 2'd1,
    TX_WAIT_DONE = 2'd2
  } tx_state_t;

  logic [7:0]            tx_mem [DEPTH];
  logic [7:0]            rx_mem [DEPTH];

  logic [DEPTH_BITS-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [DEPTH_BITS-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  tx_state_t             state_q, state_d;
  logic [2:0]            tmr_q, tmr_d;
  logic                  xmit_q, xmit_d;
  logic [7:0]            txb_q, txb_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            errc_q, errc_d;
  logic                  errp_q, errp_d;

  logic tx_full, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);

  always_comb begin
    tx_push  = bus.wr_stb && !tx_full;
    tx_pop   = (state_q == TX_IDLE) && (tx_cnt_q != '0) && !bus.uart_is_transmitting;
    // A full RX FIFO can still take a byte when the host pops in the same cycle.
    rx_push  = bus.uart_received && (!rx_full || bus.rd_stb);
    rx_pop   = bus.rd_stb && !rx_empty;

    tx_wp_d  = tx_push ? tx_wp_q + PTR_ONE : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + PTR_ONE : tx_rp_q;
    rx_wp_d  = rx_push ? rx_wp_q + PTR_ONE : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + PTR_ONE : rx_rp_q;

    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_ONE;
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_ONE;

    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_ONE;
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_ONE;

    errp_d = bus.uart_rx_error;
    ovf_d  = ovf_q;
    errc_d = errc_q;
    if (bus.status_clear) begin
      ovf_d  = 1'b0;
      errc_d = 8'h00;
    end else begin
      if (bus.uart_received && rx_full && !bus.rd_stb) ovf_d = 1'b1;
      if (bus.uart_rx_error && !errp_q && errc_q != 8'hFF) errc_d = errc_q + 8'h01;
    end

    state_d = state_q;
    tmr_d   = tmr_q;
    xmit_d  = 1'b0;
    txb_d   = txb_q;
    case (state_q)
      TX_IDLE: begin
        if (tx_pop) begin
          xmit_d  = 1'b1;
          txb_d   = tx_mem[tx_rp_q];
          tmr_d   = 3'd0;
          state_d = TX_WAIT_BUSY;
        end
      end
      TX_WAIT_BUSY: begin
        // A UART that never reports busy is given 8 cycles, then the byte counts as sent.
        if (bus.uart_is_transmitting) state_d = TX_WAIT_DONE;
        else if (tmr_q == 3'd7)       state_d = TX_IDLE;
        else                          tmr_d   = tmr_q + 3'd1;
      end
      TX_WAIT_DONE: begin
        if (!bus.uart_is_transmitting) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      state_q  <= TX_IDLE;
      tmr_q    <= 3'd0;
      xmit_q   <= 1'b0;
      txb_q    <= 8'h00;
      ovf_q    <= 1'b0;
      errc_q   <= 8'h00;
      errp_q   <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      xmit_q   <= xmit_d;
      txb_q    <= txb_d;
      ovf_q    <= ovf_d;
      errc_q   <= errc_d;
      errp_q   <= errp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= bus.wr_data;
    if (rx_push) rx_mem[rx_wp_q] <= bus.uart_rx_byte;
  end

  assign bus.uart_transmit = xmit_q;
  assign bus.uart_tx_byte  = txb_q;
  assign bus.tx_full       = tx_full;
  assign bus.tx_count      = tx_cnt_q;
  assign bus.rd_data       = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
  assign bus.rx_empty      = rx_empty;
  assign bus.rx_count      = rx_cnt_q;
  assign bus.rx_overflow   = ovf_q;
  assign bus.rx_err_count  = errc_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// tb_uart_fifo_bridge : directed self-checking bench for uart_fifo_bridge
// Revision: 1.0
// ============================================================================
module tb_uart_fifo_bridge;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic seen;

  uart_fifo_bridge_if #(.DEPTH_BITS(4)) bif ();

  uart_fifo_bridge #(.DEPTH_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bif.uart_received = 1'b0;
    bif.uart_rx_byte = 8'h00;
    bif.uart_rx_error = 1'b0;
    bif.uart_is_transmitting = 1'b0;
    bif.wr_stb = 1'b0;
    bif.wr_data = 8'h00;
    bif.rd_stb = 1'b0;
    bif.status_clear = 1'b0;
    tick();

    // reset state
    chk("rst_tx_count", 32'(bif.tx_count), 0);
    chk("rst_rx_count", 32'(bif.rx_count), 0);
    chk("rst_tx_full", 32'(bif.tx_full), 0);
    chk("rst_rx_empty", 32'(bif.rx_empty), 1);
    chk("rst_transmit", 32'(bif.uart_transmit), 0);
    chk("rst_tx_byte", 32'(bif.uart_tx_byte), 0);
    chk("rst_overflow", 32'(bif.rx_overflow), 0);
    chk("rst_err_count", 32'(bif.rx_err_count), 0);
    chk("rst_rd_data", 32'(bif.rd_data), 0);
    rst = 1'b1;
    tick();

    // two bytes launched in order, each after busy falls
    bif.wr_stb = 1'b1; bif.wr_data = 8'hA5;
    tick();
    chk("t1_count_after_push", 32'(bif.tx_count), 1);
    bif.wr_data = 8'h3C;
    tick();
    bif.wr_stb = 1'b0;
    chk("t1_launch_a5", 32'(bif.uart_transmit), 1);
    chk("t1_byte_a5", 32'(bif.uart_tx_byte), 32'hA5);
    chk("t1_count_push_pop", 32'(bif.tx_count), 1);
    bif.uart_is_transmitting = 1'b1;
    tick();
    chk("t1_pulse_one_cycle", 32'(bif.uart_transmit), 0);
    tick();
    tick();
    chk("t1_no_launch_busy", 32'(bif.uart_transmit), 0);
    chk("t1_byte_held", 32'(bif.uart_tx_byte), 32'hA5);
    bif.uart_is_transmitting = 1'b0;
    tick();
    chk("t1_idle_no_launch", 32'(bif.uart_transmit), 0);
    tick();
    chk("t1_launch_3c", 32'(bif.uart_transmit), 1);
    chk("t1_byte_3c", 32'(bif.uart_tx_byte), 32'h3C);
    chk("t1_count_empty", 32'(bif.tx_count), 0);
    bif.uart_is_transmitting = 1'b1;
    tick();
    chk("t1_pulse2_one_cycle", 32'(bif.uart_transmit), 0);
    bif.uart_is_transmitting = 1'b0;
    tick();
    tick();

    // busy never seen: 8-cycle timeout before next launch
    bif.wr_stb = 1'b1; bif.wr_data = 8'h11;
    tick();
    bif.wr_data = 8'h22;
    tick();
    bif.wr_stb = 1'b0;
    chk("t2_launch_11", 32'(bif.uart_transmit), 1);
    chk("t2_byte_11", 32'(bif.uart_tx_byte), 32'h11);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bif.uart_transmit) seen = 1'b1;
    end
    chk("t2_no_early_launch", 32'(seen), 0);
    chk("t2_count_before", 32'(bif.tx_count), 1);
    tick();
    chk("t2_launch_22", 32'(bif.uart_transmit), 1);
    chk("t2_byte_22", 32'(bif.uart_tx_byte), 32'h22);
    chk("t2_count_after", 32'(bif.tx_count), 0);
    for (int k = 0; k < 9; k++) tick();

    // TX full while UART busy; 17th push ignored
    bif.uart_is_transmitting = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bif.wr_stb = 1'b1; bif.wr_data = 8'(32'h60 + i);
      tick();
    end
    bif.wr_stb = 1'b0;
    chk("t3_tx_count_full", 32'(bif.tx_count), 16);
    chk("t3_tx_full", 32'(bif.tx_full), 1);
    bif.uart_is_transmitting = 1'b0;
    tick();
    chk("t3_launch_head", 32'(bif.uart_transmit), 1);
    chk("t3_head_byte", 32'(bif.uart_tx_byte), 32'h60);
    chk("t3_count_15", 32'(bif.tx_count), 15);
    bif.uart_is_transmitting = 1'b1;
    tick();

    // reset mid-transmit with bytes queued
    rst = 1'b0;
    #2;
    chk("t4_async_tx_count", 32'(bif.tx_count), 0);
    chk("t4_async_transmit", 32'(bif.uart_transmit), 0);
    chk("t4_async_tx_byte", 32'(bif.uart_tx_byte), 0);
    chk("t4_async_tx_full", 32'(bif.tx_full), 0);
    tick();
    rst = 1'b1;
    bif.uart_is_transmitting = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bif.uart_transmit) seen = 1'b1;
    end
    chk("t4_no_launch_after", 32'(seen), 0);
    chk("t4_count_zero", 32'(bif.tx_count), 0);

    // RX overflow: 17 bytes, no reads
    for (int i = 0; i < 17; i++) begin
      bif.uart_received = 1'b1; bif.uart_rx_byte = 8'(32'h40 + i);
      tick();
    end
    bif.uart_received = 1'b0;
    chk("t5_rx_count", 32'(bif.rx_count), 16);
    chk("t5_overflow", 32'(bif.rx_overflow), 1);
    chk("t5_rx_empty", 32'(bif.rx_empty), 0);
    for (int i = 0; i < 16; i++) begin
      chk("t5_read_order", 32'(bif.rd_data), 32'h40 + i);
      bif.rd_stb = 1'b1;
      tick();
      bif.rd_stb = 1'b0;
    end
    chk("t5_empty_after", 32'(bif.rx_empty), 1);
    chk("t5_rd_data_empty", 32'(bif.rd_data), 0);
    bif.rd_stb = 1'b1;
    tick();
    bif.rd_stb = 1'b0;
    chk("t5_pop_empty_ignored", 32'(bif.rx_count), 0);
    chk("t5_overflow_sticky", 32'(bif.rx_overflow), 1);
    bif.status_clear = 1'b1;
    tick();
    bif.status_clear = 1'b0;
    chk("t5_overflow_cleared", 32'(bif.rx_overflow), 0);

    // RX full with simultaneous push and pop
    for (int i = 0; i < 16; i++) begin
      bif.uart_received = 1'b1; bif.uart_rx_byte = 8'(32'h80 + i);
      tick();
    end
    bif.uart_rx_byte = 8'hEE; bif.rd_stb = 1'b1;
    tick();
    bif.uart_received = 1'b0; bif.rd_stb = 1'b0;
    chk("t6_count_stays", 32'(bif.rx_count), 16);
    chk("t6_no_overflow", 32'(bif.rx_overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk("t6_read_order", 32'(bif.rd_data), (i < 15) ? 32'h81 + i : 32'hEE);
      bif.rd_stb = 1'b1;
      tick();
      bif.rd_stb = 1'b0;
    end
    chk("t6_empty_after", 32'(bif.rx_count), 0);

    // framing-error counter: edges, saturation, clear priority
    for (int i = 0; i < 3; i++) begin
      bif.uart_rx_error = 1'b1; tick();
      tick();
      bif.uart_rx_error = 1'b0; tick();
    end
    chk("t7_err_count_3", 32'(bif.rx_err_count), 3);
    for (int i = 0; i < 297; i++) begin
      bif.uart_rx_error = 1'b1; tick();
      bif.uart_rx_error = 1'b0; tick();
    end
    chk("t7_err_saturated", 32'(bif.rx_err_count), 255);
    bif.uart_rx_error = 1'b1; bif.status_clear = 1'b1;
    tick();
    bif.uart_rx_error = 1'b0; bif.status_clear = 1'b0;
    chk("t7_clear_wins", 32'(bif.rx_err_count), 0);
    tick();
    chk("t7_stays_clear", 32'(bif.rx_err_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
